// File: rtl/coin_return.sv
`default_nettype none
// ============================================================================
// Module      : coin_return
// Description : Change-return FSM. Pays out a latched balance as the largest
//               coins first, then pulses balance_clear. Define the macro
//               COIN_RETURN_REQ_EN to let return_req start a payout.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_return #(
    parameter int BAL_W    = 31,
    parameter int COIN_LO  = 100,
    parameter int COIN_MID = 500,
    parameter int COIN_HI  = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             activity,
    input  logic             timeout,
    input  logic [BAL_W-1:0] balance,
    input  logic             return_req,
    input  logic             coin_ready,
    output logic             timeset,
    output logic             coin_valid,
    output logic [1:0]       coin_type,
    output logic             balance_clear,
    output logic             busy
);

    localparam logic [BAL_W-1:0] c_lo  = BAL_W'(COIN_LO);
    localparam logic [BAL_W-1:0] c_mid = BAL_W'(COIN_MID);
    localparam logic [BAL_W-1:0] c_hi  = BAL_W'(COIN_HI);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPENSE = 2'd1,
        S_DONE     = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BAL_W-1:0] remaining_q, remaining_d;
    logic             timeset_q, timeset_d;
    logic             coin_valid_q, coin_valid_d;
    logic [1:0]       coin_type_q, coin_type_d;
    logic             balance_clear_q, balance_clear_d;
    logic             busy_q, busy_d;
    logic             w_trigger;

    function automatic logic [1:0] pick_coin(input logic [BAL_W-1:0] amt);
        if (amt >= c_hi) begin
            return 2'd2;
        end else if (amt >= c_mid) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

    function automatic logic [BAL_W-1:0] coin_value(input logic [1:0] ctype);
        case (ctype)
            2'd2:    return c_hi;
            2'd1:    return c_mid;
            default: return c_lo;
        endcase
    endfunction

`ifdef COIN_RETURN_REQ_EN
    // A manual request bypasses the timer entirely, including the reload cycle.
    assign w_trigger = (|balance) && ((timeout && !timeset_q) || return_req);
`else
    logic w_unused_return_req;
    assign w_unused_return_req = return_req;
    assign w_trigger           = (|balance) && timeout && !timeset_q;
`endif

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        timeset_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_trigger) begin
                    remaining_d = balance;
                    state_d     = S_DISPENSE;
                end else if (activity) begin
                    timeset_d = 1'b1;
                end
            end
            S_DISPENSE: begin
                // Coin type always derives from remaining_q, so the subtraction cannot underflow.
                if (remaining_q < c_lo) begin
                    state_d = S_DONE;
                end else if (coin_valid_q && coin_ready) begin
                    remaining_d = remaining_q - coin_value(coin_type_q);
                    if (remaining_d < c_lo) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                remaining_d = '0;
                state_d     = S_IDLE;
            end
            default: begin
                remaining_d = '0;
                state_d     = S_IDLE;
            end
        endcase

        coin_valid_d    = (state_d == S_DISPENSE) && (remaining_d >= c_lo);
        coin_type_d     = coin_valid_d ? pick_coin(remaining_d) : 2'd0;
        balance_clear_d = (state_d == S_DONE);
        busy_d          = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            remaining_q     <= '0;
            timeset_q       <= 1'b0;
            coin_valid_q    <= 1'b0;
            coin_type_q     <= 2'd0;
            balance_clear_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            remaining_q     <= remaining_d;
            timeset_q       <= timeset_d;
            coin_valid_q    <= coin_valid_d;
            coin_type_q     <= coin_type_d;
            balance_clear_q <= balance_clear_d;
            busy_q          <= busy_d;
        end
    end

    assign timeset       = timeset_q;
    assign coin_valid    = coin_valid_q;
    assign coin_type     = coin_type_q;
    assign balance_clear = balance_clear_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_return.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_return
// Description : Scoreboard bench for coin_return; expected coin/clear/timeset
//               events are queued by the stimulus and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_return;

    localparam int BAL_W = 31;
    localparam int EV_CLEAR   = 4;
    localparam int EV_TIMESET = 5;

    logic             clk;
    logic             reset_n;
    logic             activity;
    logic             timeout;
    logic [BAL_W-1:0] balance;
    logic             return_req;
    logic             coin_ready;
    logic             timeset;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             balance_clear;
    logic             busy;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    coin_return #(
        .BAL_W    (BAL_W),
        .COIN_LO  (100),
        .COIN_MID (500),
        .COIN_HI  (1000)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .activity      (activity),
        .timeout       (timeout),
        .balance       (balance),
        .return_req    (return_req),
        .coin_ready    (coin_ready),
        .timeset       (timeset),
        .coin_valid    (coin_valid),
        .coin_type     (coin_type),
        .balance_clear (balance_clear),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sb_pop(input string name, input int act);
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: unexpected event code %0d, scoreboard empty at %0t", name, act, $time);
        end else begin
            int e;
            e = exp_q.pop_front();
            if (e != act) begin
                n_errors++;
                $display("FAIL %s: got event %0d expected %0d at %0t", name, act, e, $time);
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (coin_valid && coin_ready) sb_pop("coin", int'(coin_type));
            if (balance_clear)            sb_pop("clear", EV_CLEAR);
            if (timeset)                  sb_pop("timeset", EV_TIMESET);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        activity   = 1'b0;
        timeout    = 1'b0;
        balance    = '0;
        return_req = 1'b0;
        coin_ready = 1'b0;
        tick(2);
        chk("reset_busy", busy, 0);
        chk("reset_coin_valid", coin_valid, 0);
        chk("reset_timeset", timeset, 0);
        chk("reset_balance_clear", balance_clear, 0);
        chk("reset_coin_type", coin_type, 0);
        reset_n = 1'b1;
        tick(1);

        // 1700 -> 1000,500,100,100 then clear; activity and balance changes ignored while busy
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
        exp_q.push_back(EV_CLEAR);
        balance = 1700; timeout = 1'b1; coin_ready = 1'b1;
        tick(1);
        timeout = 1'b0; balance = 5; activity = 1'b1;
        chk("t1700_busy", busy, 1);
        chk("t1700_first_type", coin_type, 2);
        tick(1);
        activity = 1'b0;
        tick(3);
        chk("t1700_clear_cycle", balance_clear, 1);
        tick(1);
        chk("t1700_busy_after", busy, 0);
        chk("t1700_clear_one_cycle", balance_clear, 0);
        balance = 0; coin_ready = 1'b0;
        tick(1);

        // 600 with chute stalled three cycles
        exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(EV_CLEAR);
        balance = 600; timeout = 1'b1;
        tick(1);
        timeout = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t600_hold_valid", coin_valid, 1);
            chk("t600_hold_type", coin_type, 1);
            if (i < 2) tick(1);
        end
        coin_ready = 1'b1;
        tick(1);
        chk("t600_second_type", coin_type, 0);
        tick(2);
        chk("t600_busy_after", busy, 0);
        balance = 0; coin_ready = 1'b0;

        // Zero balance never dispenses; activity gives a one-cycle timeset
        timeout = 1'b1;
        tick(3);
        chk("t0_busy", busy, 0);
        chk("t0_coin_valid", coin_valid, 0);
        exp_q.push_back(EV_TIMESET);
        activity = 1'b1;
        tick(1);
        activity = 1'b0;
        chk("t0_timeset_pulse", timeset, 1);
        balance = 300;
        tick(1);
        // Trigger is blocked in the cycle timeset is high
        chk("t0_timeset_single", timeset, 0);
        chk("t0_no_trigger_during_timeset", busy, 0);
        timeout = 1'b0; balance = 0;
        tick(1);

        // Activity coinciding with trigger: trigger wins, no timeset
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(EV_CLEAR);
        balance = 300; timeout = 1'b1; activity = 1'b1; coin_ready = 1'b1;
        tick(1);
        activity = 1'b0; timeout = 1'b0;
        chk("t300_busy", busy, 1);
        chk("t300_no_timeset", timeset, 0);
        tick(4);
        chk("t300_busy_after", busy, 0);
        balance = 0;

        // Balance below the smallest coin: straight to clear, no coin offered
        exp_q.push_back(EV_CLEAR);
        balance = 50; timeout = 1'b1;
        tick(1);
        timeout = 1'b0;
        chk("t50_busy", busy, 1);
        chk("t50_no_coin", coin_valid, 0);
        tick(2);
        chk("t50_busy_after", busy, 0);
        balance = 0; coin_ready = 1'b0;

        // Reset during the first offer aborts without a clear
        balance = 1000; timeout = 1'b1;
        tick(1);
        timeout = 1'b0;
        chk("t1000_offer_valid", coin_valid, 1);
        chk("t1000_offer_type", coin_type, 2);
        reset_n = 1'b0;
        tick(1);
        chk("t1000_rst_valid", coin_valid, 0);
        chk("t1000_rst_busy", busy, 0);
        chk("t1000_rst_type", coin_type, 0);
        chk("t1000_rst_clear", balance_clear, 0);
        reset_n = 1'b1; balance = 0;
        tick(3);
        chk("t1000_idle_after", busy, 0);

        // Manual return request with timeout low
        balance = 250; coin_ready = 1'b1;
`ifdef COIN_RETURN_REQ_EN
        exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(EV_CLEAR);
        return_req = 1'b1;
        tick(1);
        return_req = 1'b0;
        chk("t250_req_busy", busy, 1);
        tick(3);
        chk("t250_req_busy_after", busy, 0);
`else
        return_req = 1'b1;
        tick(1);
        return_req = 1'b0;
        chk("t250_req_ignored", busy, 0);
        tick(3);
        chk("t250_req_still_idle", busy, 0);
`endif
        balance = 0; coin_ready = 1'b0;
        tick(3);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coin_return.md
COIN_RETURN -- requirements
Module: coin_return

Interface
REQ-001 Parameter BAL_W, default 31, SHALL set the width of the balance bus and of the internal remaining-change register.
REQ-002 Parameter COIN_LO/COIN_MID/COIN_HI, defaults 100/500/1000, SHALL set the coin denominations.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 activity  in  1  single-cycle pulse for any user event (coin insert, item select).
REQ-006 timeout  in  1  high while the wait timer has expired.
REQ-007 balance  in  BAL_W  current customer balance from the datapath.
REQ-008 return_req  in  1  manual change-return pulse (used only with COIN_RETURN_REQ_EN).
REQ-009 coin_ready  in  1  coin chute can accept a coin this cycle.
REQ-010 timeset  out  1  registered single-cycle pulse to reload the wait timer.
REQ-011 coin_valid  out  1  a coin is being offered to the chute.
REQ-012 coin_type  out  2  coin offered: 0=COIN_LO, 1=COIN_MID, 2=COIN_HI, 3 never driven.
REQ-013 balance_clear  out  1  single-cycle pulse telling the datapath to zero its balance.
REQ-014 busy  out  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, DISPENSE, DONE.
REQ-016 IDLE: activity SHALL produce timeset=1 in the next cycle only; activity outside IDLE SHALL be ignored.
REQ-017 IDLE: trigger = timeout && balance != 0 && !timeset; on trigger, remaining <= balance and next state DISPENSE.
REQ-018 Triggering SHALL NOT occur in the cycle timeset is high (timer not yet reloaded).
REQ-019 If activity and trigger coincide in IDLE, trigger SHALL win and no timeset SHALL be issued.
REQ-020 DISPENSE: coin_valid=1; coin_type = largest denomination <= remaining, selected from the registered remaining value.
REQ-021 coin_valid and coin_type SHALL stay stable until coin_valid && coin_ready.
REQ-022 On a handshake cycle, remaining SHALL decrease by the offered coin's value at the next edge; exactly one coin per handshake.
REQ-023 If remaining after subtraction < COIN_LO, next state SHALL be DONE; residue < COIN_LO is forfeited, never offered.
REQ-024 If remaining < COIN_LO on DISPENSE entry (e.g. balance=50), the FSM SHALL go to DONE with no coin offered.
REQ-025 DONE: balance_clear=1 for exactly one cycle, then IDLE.
REQ-026 balance changes while busy SHALL be ignored; only the latched remaining value is used.
REQ-027 Subtraction SHALL never underflow; remaining is unsigned BAL_W bits.
REQ-028 With coin_ready held high, a balance of N coins SHALL finish in N+1 cycles after DISPENSE entry (N handshakes + DONE).

Reset
REQ-029 While reset_n=0 at a rising edge: state<=IDLE, remaining<=0, timeset=0, coin_valid=0, coin_type=0, balance_clear=0, busy=0.
REQ-030 Reset mid-DISPENSE SHALL abort immediately; no balance_clear SHALL be issued for the aborted transaction.

Configuration
REQ-031 Macro COIN_RETURN_REQ_EN defined: return_req in IDLE with balance != 0 SHALL trigger exactly as REQ-017, regardless of timeout and timeset.
REQ-032 Macro undefined: return_req SHALL be ignored; the port SHALL remain present; only timeout triggers dispensing.

Verification
REQ-033 balance=1700, timeout=1, coin_ready=1 -> coin_type 2,1,0,0 on consecutive cycles, then balance_clear one cycle, busy low after.
REQ-034 balance=600, coin_ready low 3 cycles -> coin_type=1 held stable with coin_valid=1 for 3 cycles, then handshake, then coin_type=0 once, then balance_clear.
REQ-035 balance=0, timeout=1 -> no coin_valid, no balance_clear, busy stays 0; activity pulse -> timeset=1 the next cycle only.
REQ-036 balance=1000, reset_n=0 during first coin offer -> all outputs 0 next cycle, no balance_clear.
REQ-037 COIN_RETURN_REQ_EN defined, timeout=0, balance=250, return_req pulse -> coin_type 0,0 then balance_clear; residue 50 not offered. Macro undefined, same stimulus -> no response.
